// File: rtl/spmv_pkg.sv
// rtl/spmv_pkg.sv - shared types and helpers for the SpMV network output arbiter
package spmv_pkg;

  localparam int SPMV_NETWORK_WIDTH = 32;

  typedef logic [$clog2(SPMV_NETWORK_WIDTH)-1:0] lane_idx_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } drain_state_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/spmv_rr_arbiter.sv
// rtl/spmv_rr_arbiter.sv - round-robin grant search starting at ptr, wrapping
// Purely combinational; the caller owns the pointer.
module spmv_rr_arbiter #(
  parameter int N  = 32,
  parameter int LW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [LW-1:0] idx,
  output logic          gnt_valid
);

  logic [LW-1:0] cand;
  logic          found;

  // N is a power of two, so LW-bit addition wraps the search for free.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    cand  = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      cand = ptr + LW'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    gnt_valid = en && found;
    if (gnt_valid) begin
      gnt[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/spmv_network_out_arbiter.sv
// rtl/spmv_network_out_arbiter.sv - merges reduction-network lanes into one registered stream
// Optional SPMV_ARB_STATS_EN adds saturating grant/stall counters.
module spmv_network_out_arbiter
  import spmv_pkg::*;
#(
  parameter int NETWORK_WIDTH = 32,
  parameter int ID_WIDTH      = 5,
  parameter int VAL_WIDTH     = 64
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [NETWORK_WIDTH-1:0]                lane_valid,
  input  logic [NETWORK_WIDTH-1:0][ID_WIDTH-1:0]  lane_id,
  input  logic [NETWORK_WIDTH-1:0][VAL_WIDTH-1:0] lane_val,
  output logic [NETWORK_WIDTH-1:0]                lane_ready,
  output logic                                    out_valid,
  output logic [$clog2(NETWORK_WIDTH)-1:0]        out_lane,
  output logic [ID_WIDTH-1:0]                     out_id,
  output logic [VAL_WIDTH-1:0]                    out_val,
  input  logic                                    out_ready,
  input  logic                                    drain_req,
  output logic                                    drain_done
`ifdef SPMV_ARB_STATS_EN
  ,
  output logic [31:0]                             stat_grants,
  output logic [31:0]                             stat_stalls
`endif
);

  localparam int LW = $clog2(NETWORK_WIDTH);

  logic [LW-1:0] ptr;
  logic [LW-1:0] gnt_idx;
  logic          gnt_valid;
  logic          free;
  logic          net_empty;
  logic          empty_seen;
  logic          empty_seen_n;
  drain_state_t  state;
  drain_state_t  state_n;

  assign free = !out_valid || out_ready;

  // Reset gates the enable so no lane sees ready while the word is being discarded.
  spmv_rr_arbiter #(
    .N (NETWORK_WIDTH),
    .LW(LW)
  ) u_rr (
    .req      (lane_valid),
    .ptr      (ptr),
    .en       (free && !rst),
    .gnt      (lane_ready),
    .idx      (gnt_idx),
    .gnt_valid(gnt_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_lane  <= '0;
      out_id    <= '0;
      out_val   <= '0;
      ptr       <= '0;
    end else if (gnt_valid) begin
      out_valid <= 1'b1;
      out_lane  <= gnt_idx;
      out_id    <= lane_id[gnt_idx];
      out_val   <= lane_val[gnt_idx];
      ptr       <= gnt_idx + LW'(1);
    end else if (free) begin
      out_valid <= 1'b0;
    end
  end

  assign net_empty = (lane_valid == '0) && !out_valid;

  // Two empty cycles in a row are needed to ride over a pipeline bubble in the network.
  always_comb begin
    state_n      = state;
    empty_seen_n = empty_seen;
    case (state)
      RUN: begin
        empty_seen_n = 1'b0;
        if (drain_req) begin
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (net_empty) begin
          empty_seen_n = 1'b1;
          if (empty_seen) begin
            state_n = DONE;
          end
        end else begin
          empty_seen_n = 1'b0;
        end
      end
      DONE: begin
        empty_seen_n = 1'b0;
        if ((|lane_valid) || drain_req) begin
          state_n = RUN;
        end
      end
      default: begin
        state_n      = RUN;
        empty_seen_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      empty_seen <= 1'b0;
      drain_done <= 1'b0;
    end else begin
      state      <= state_n;
      empty_seen <= empty_seen_n;
      drain_done <= (state_n == DONE);
    end
  end

`ifdef SPMV_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_grants <= '0;
      stat_stalls <= '0;
    end else begin
      if (gnt_valid) begin
        stat_grants <= sat_inc32(stat_grants);
      end
      if (out_valid && !out_ready) begin
        stat_stalls <= sat_inc32(stat_stalls);
      end
    end
  end
`endif

endmodule
